// File: rtl/sum_sched.sv
// sum_sched: adds N unsigned operands on P shared adders over several cycles.
// The operands are paired, then accumulated lane-wise, then reduced as a tree.
module sum_sched #(
    parameter  int N  = 45,
    parameter  int W  = 5,
    parameter  int P  = 10,
    localparam int OW = W + $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] nums,
    output logic           busy,
    output logic [OW-1:0]  sum,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     cycles
);

    localparam int CW = $clog2(N + 2*P + 1);
    localparam int R0 = (P < (N + 1) / 2) ? P : (N + 1) / 2;
    localparam int I0 = (N < 2*P) ? N : 2*P;
    localparam int XW = (N + 2*P) * W;
    localparam int AW = P * W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N*W-1:0]   op_q, op_d;
    logic [OW-1:0]    part_q [P];
    logic [OW-1:0]    part_d [P];
    logic [CW-1:0]    r_q, r_d;
    logic [CW-1:0]    i_q, i_d;
    logic [OW-1:0]    sum_q, sum_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       cyc_q, cyc_d;

    logic [XW-1:0]    opx;
    logic [AW-1:0]    rest;
    logic [OW-1:0]    partx [2*P];
    logic [OW-1:0]    pair_s [P];
    logic [OW-1:0]    acc_n [P];
    logic [OW-1:0]    red_n [P];
    logic [CW-1:0]    left;
    logic [CW-1:0]    n_acc;
    logic [CW-1:0]    half;

    // Zero padding lets every lane read a pair without range guards.
    assign opx   = {{(2*P*W){1'b0}}, op_q};
    assign rest  = AW'(opx >> (int'(i_q) * W));
    assign left  = CW'(N) - i_q;
    assign n_acc = (r_q < left) ? r_q : left;
    assign half  = r_q >> 1;

    for (genvar g = 0; g < 2*P; g++) begin : g_px
        if (g < P) begin : g_live
            assign partx[g] = part_q[g];
        end else begin : g_pad
            assign partx[g] = '0;
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_lane
        logic [OW-1:0] acc_s;
        logic [OW-1:0] red_s;

        assign pair_s[g] = OW'(opx[2*g*W +: W])
                         + OW'(opx[(2*g+1)*W +: W]);
        assign acc_s     = part_q[g] + OW'(rest[g*W +: W]);
        assign red_s     = partx[2*g] + partx[2*g+1];

        assign acc_n[g] = (CW'(g) < n_acc) ? acc_s : part_q[g];

        // An odd survivor moves down to sit next to the reduced pairs.
        always_comb begin
            red_n[g] = part_q[g];
            if (CW'(g) < half) begin
                red_n[g] = red_s;
            end else if (r_q[0] && CW'(g) == half) begin
                red_n[g] = partx[2*g];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        part_d  = part_q;
        r_d     = r_q;
        i_d     = i_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = nums;
                    cyc_d   = '0;
                    r_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                cyc_d = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
                // r_q is zero only on the first cycle of a job.
                if (r_q == '0) begin
                    part_d = pair_s;
                    r_d    = CW'(R0);
                    i_d    = CW'(I0);
                end else if (i_q != CW'(N)) begin
                    part_d = acc_n;
                    i_d    = i_q + n_acc;
                end else begin
                    part_d = red_n;
                    r_d    = (r_q + CW'(1)) >> 1;
                end
                if (i_d == CW'(N) && r_d == CW'(1)) begin
                    sum_d   = part_d[0];
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            part_q  <= '{default: '0};
            r_q     <= '0;
            i_q     <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            part_q  <= part_d;
            r_q     <= r_d;
            i_q     <= i_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cyc_q   <= cyc_d;
        end
    end

    assign busy      = busy_q;
    assign sum       = sum_q;
    assign out_valid = valid_q;
    assign cycles    = cyc_q;

endmodule

// File: tb/tb_sum_sched.sv
// tb_sum_sched: random and directed jobs on three sum_sched configurations,
// results checked by per-instance monitors against queued reference results.
module tb_sum_sched;

    localparam int N  = 45;
    localparam int W  = 5;
    localparam int P  = 10;
    localparam int NW = N * W;
    localparam int OW = W + $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           start = 1'b0;
    logic           out_ready = 1'b1;
    logic [NW-1:0]  nums = '0;
    logic           busy, out_valid;
    logic [OW-1:0]  sum;
    logic [7:0]     cycles;

    logic           s3_start = 1'b0;
    logic [14:0]    s3_nums = '0;
    logic           s3_busy, s3_valid;
    logic [6:0]     s3_sum;
    logic [7:0]     s3_cycles;

    logic           s8_start = 1'b0;
    logic [39:0]    s8_nums = '0;
    logic           s8_busy, s8_valid;
    logic [7:0]     s8_sum;
    logic [7:0]     s8_cycles;

    logic           rdy_s = 1'b1;

    sum_sched #(.N(N), .W(W), .P(P)) u_main (
        .clk(clk), .rst(rst), .start(start), .nums(nums),
        .busy(busy), .sum(sum), .out_valid(out_valid),
        .out_ready(out_ready), .cycles(cycles)
    );

    sum_sched #(.N(3), .W(5), .P(10)) u_n3 (
        .clk(clk), .rst(rst), .start(s3_start), .nums(s3_nums),
        .busy(s3_busy), .sum(s3_sum), .out_valid(s3_valid),
        .out_ready(rdy_s), .cycles(s3_cycles)
    );

    sum_sched #(.N(8), .W(5), .P(1)) u_n8 (
        .clk(clk), .rst(rst), .start(s8_start), .nums(s8_nums),
        .busy(s8_busy), .sum(s8_sum), .out_valid(s8_valid),
        .out_ready(rdy_s), .cycles(s8_cycles)
    );

    typedef struct {
        int     s;
        int     c;
        longint due;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    exp_t q8[$];
    exp_t cur, e3, e8;
    int   nchk = 0;
    int   nfail = 0;
    logic pv = 1'b0, pr = 1'b0, pv3 = 1'b0, pv8 = 1'b0;
    logic [NW-1:0] v;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input longint act);
        nchk++;
        nfail++;
        $display("FAIL %s: got output sum %0d, expected no output", nm, act);
    endtask

    // Pair step, then R0 operands absorbed per cycle, then a log2 tree.
    function automatic int exp_cyc(input int n, input int p);
        int r0, rem, c;
        r0  = (p < (n + 1) / 2) ? p : (n + 1) / 2;
        rem = n - 2 * p;
        c   = 1;
        if (rem > 0) c += (rem + r0 - 1) / r0;
        c += $clog2(r0);
        return (c > 255) ? 255 : c;
    endfunction

    function automatic int sum_of(input logic [NW-1:0] x, input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(x[k*W +: W]);
        return s;
    endfunction

    always @(negedge clk) begin
        if (out_valid && !pv) begin
            if (q0.size() == 0) begin
                unexpected("main_unexpected_valid", sum);
            end else begin
                cur = q0.pop_front();
                chk("main_sum", sum, cur.s);
                chk("main_cycles", cycles, cur.c);
                chk("main_latency", $time, cur.due);
                chk("main_busy_done", busy, 1);
            end
        end else if (out_valid) begin
            if (pr) begin
                chk("main_valid_after_accept", out_valid, 0);
            end else begin
                chk("main_hold_sum", sum, cur.s);
                chk("main_hold_cycles", cycles, cur.c);
            end
        end
        pv = out_valid;
        pr = out_ready;
    end

    always @(negedge clk) begin
        if (s3_valid && !pv3) begin
            if (q3.size() == 0) begin
                unexpected("n3_unexpected_valid", s3_sum);
            end else begin
                e3 = q3.pop_front();
                chk("n3_sum", s3_sum, e3.s);
                chk("n3_cycles", s3_cycles, e3.c);
                chk("n3_latency", $time, e3.due);
            end
        end
        pv3 = s3_valid;
    end

    always @(negedge clk) begin
        if (s8_valid && !pv8) begin
            if (q8.size() == 0) begin
                unexpected("n8_unexpected_valid", s8_sum);
            end else begin
                e8 = q8.pop_front();
                chk("n8_sum", s8_sum, e8.s);
                chk("n8_cycles", s8_cycles, e8.c);
                chk("n8_latency", $time, e8.due);
            end
        end
        pv8 = s8_valid;
    end

    task automatic job0(input logic [NW-1:0] x, input bit clr, input bit push);
        longint t;
        int     c;
        nums  = x;
        start = 1'b1;
        @(posedge clk);
        t = $time;
        c = exp_cyc(N, P);
        if (push) q0.push_back('{s: sum_of(x, N), c: c, due: t + c * 10 + 5});
        @(negedge clk);
        start = 1'b0;
        if (clr) nums = '0;
    endtask

    task automatic job3(input logic [14:0] x);
        longint t;
        int     c;
        s3_nums  = x;
        s3_start = 1'b1;
        @(posedge clk);
        t = $time;
        c = exp_cyc(3, 10);
        q3.push_back('{s: sum_of(NW'(x), 3), c: c, due: t + c * 10 + 5});
        @(negedge clk);
        s3_start = 1'b0;
    endtask

    task automatic job8(input logic [39:0] x);
        longint t;
        int     c;
        s8_nums  = x;
        s8_start = 1'b1;
        @(posedge clk);
        t = $time;
        c = exp_cyc(8, 1);
        q8.push_back('{s: sum_of(NW'(x), 8), c: c, due: t + c * 10 + 5});
        @(negedge clk);
        s8_start = 1'b0;
    endtask

    task automatic wait_all();
        int i = 0;
        while ((q0.size() != 0 || q3.size() != 0 || q8.size() != 0 ||
                busy || s3_busy || s8_busy) && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) begin
            nchk++;
            nfail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0",
                     q0.size() + q3.size() + q8.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_n3_valid", s3_valid, 0);
        chk("rst_n8_cycles", s8_cycles, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < N; k++) v[k*W +: W] = 5'd31;
        job0(v, 1'b0, 1'b1);
        wait_all();

        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1);
        job0(v, 1'b1, 1'b1);
        wait_all();

        repeat (10) begin
            for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom_range(0, 31));
            job0(v, 1'($urandom_range(0, 1)), 1'b1);
            wait_all();
        end

        // Consumer stalls; a start during DONE must be ignored.
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom_range(0, 31));
        job0(v, 1'b0, 1'b1);
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        chk("stall_valid_seen", out_valid, 1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        nums  = ~'0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_valid", out_valid, 0);
        chk("handoff_busy", busy, 0);
        repeat (15) @(negedge clk);
        chk("no_restart_busy", busy, 0);
        chk("stall_result_popped", q0.size(), 0);

        // Abandon a job during its fourth RUN cycle.
        for (int k = 0; k < N; k++) v[k*W +: W] = 5'd31;
        job0(v, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cycles", cycles, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        for (int k = 0; k < N; k++) v[k*W +: W] = 5'd1;
        job0(v, 1'b0, 1'b1);
        wait_all();

        job3({5'd3, 5'd2, 5'd1});
        wait_all();
        job8({8{5'd31}});
        wait_all();
        repeat (4) begin
            job3(15'($urandom));
            job8(40'({$urandom, $urandom}));
            wait_all();
        end

        chk("queues_empty", q0.size() + q3.size() + q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/sum_sched.md
SUM_SCHED -- requirements
Module: sum_sched

Interface
REQ-001 Parameter N, default 45: number of unsigned operands per job, N >= 2.
REQ-002 Parameter W, default 5: width of each operand in bits.
REQ-003 Parameter P, default 10: number of shared 2-input adders (partial-sum lanes), P >= 1.
REQ-004 Derived OW = W + ceil(log2(N)), which is 11 at the defaults; the block SHALL NOT override it.
REQ-005 Port clk, input, 1 bit: single clock, rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 Port nums, input, N*W bits: operand k (0-based) occupies bits [k*W +: W].
REQ-009 Port busy, output, 1 bit: high in RUN and DONE.
REQ-010 Port sum, output, OW bits: final sum, meaningful while out_valid is high.
REQ-011 Port out_valid, output, 1 bit: result available.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 Port cycles, output, 8 bits: count of RUN cycles used by the last job.

Function
REQ-014 The block SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at a clock edge, the block SHALL capture nums into an internal operand register, clear cycles and enter RUN; later changes on nums SHALL NOT affect the job.
REQ-016 Internal state SHALL comprise P partial registers of OW bits (part[0..P-1]), a live-partial count R and a next-operand index I.
REQ-017 First RUN cycle (pair step): for each k<P, if 2k+1<N then part[k]=op[2k]+op[2k+1]; else if 2k<N then part[k]=op[2k]; R=min(P,ceil(N/2)); I=min(N,2P).
REQ-018 Later RUN cycles with I<N (accumulate step): for each k<min(R,N-I), part[k]=part[k]+op[I+k]; other lanes SHALL hold their value; I advances by min(R,N-I).
REQ-019 RUN cycles with I==N and R>1 (reduce step): for each k<floor(R/2), part[k]=part[2k]+part[2k+1]; if R is odd, part[floor(R/2)]=part[R-1]; R=ceil(R/2).
REQ-020 Each RUN cycle SHALL use at most P additions; every addition SHALL be unsigned, zero-extended to OW bits, with no overflow possible.
REQ-021 Each RUN cycle SHALL increment cycles, saturating at 255.
REQ-022 When a RUN cycle leaves R==1 and I==N, the next state SHALL be DONE, with sum=part[0] and out_valid=1 registered on that same edge.
REQ-023 At the defaults the schedule SHALL take exactly 8 RUN cycles: pair, accumulate x3 (I = 30, 40, 45), then reduce x4 (R = 5, 3, 2, 1).
REQ-024 In DONE, out_valid, sum and cycles SHALL hold until out_valid and out_ready are both high at an edge; the block SHALL then return to IDLE with out_valid=0 while sum and cycles keep their last values.
REQ-025 start SHALL be ignored in RUN and DONE, and also in the DONE->IDLE handoff cycle; a new job is accepted only from IDLE.
REQ-026 busy SHALL be a registered output, equal to 1 exactly when the state is RUN or DONE.

Reset
REQ-027 While rst=0, the block SHALL immediately, asynchronously, force IDLE, busy=0, out_valid=0, sum=0, cycles=0, all part[]=0, R=0 and I=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abandon the job with no output pulse; after release, the first start SHALL run a full fresh job.

Verification
REQ-029 Defaults, all operands 31, start pulsed for 1 cycle, out_ready=1 -> out_valid rises on the 8th edge after the accept edge; sum=1395; cycles=8; out_valid is high for 1 cycle.
REQ-030 Defaults, operand k = k+1, nums changed to all-zero the cycle after accept -> sum=1035.
REQ-031 out_ready held 0 for 5 cycles after out_valid, start pulsed during DONE -> sum/out_valid stable; no new job starts; IDLE follows the first cycle with out_ready=1.
REQ-032 rst pulled low at RUN cycle 4, then released, then a new start with all operands 1 -> no out_valid for the aborted job; new result sum=45, cycles=8.
REQ-033 N=3, P=10, operands 1,2,3 -> 2 RUN cycles (pair, reduce); sum=6; cycles=2.
REQ-034 N=8, P=1, all operands 31 -> one addition per cycle (1 pair + 6 accumulate); sum=248; cycles=7.
